// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI register-access target.
// Build option: define SPI_TARGET_AUTOINC_EN to enable address auto-increment bursts.
package spi_target_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  // Command byte layout: bit7 selects read(1)/write(0), bits6:0 carry the address
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int CMD_ADDR_LSB = 0;

  // Byte shifted out on miso for read bytes that have no backing register access
  localparam logic [DATA_W-1:0] FILLER_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  // Burst address step, wrapping 7'h7F -> 7'h00
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return addr + 7'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;
  logic              level;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi = gi + 1) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous pin
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[0] <= IDLE_LEVEL;
          else        sync_reg[0] <= din;
        end
      end else begin : g_next
        // Later stages give metastability time to resolve
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= IDLE_LEVEL;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign level = sync_reg[STAGES-1];

  // Previous synchronized level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= IDLE_LEVEL;
    else        prev_reg <= level;
  end

  assign rise = level & ~prev_reg;
  assign fall = ~level & prev_reg;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target bridging a serial controller onto a simple register bus.
// First byte of a frame is the command (read/write + 7-bit address), the next
// byte carries data. Build option SPI_TARGET_AUTOINC_EN continues the burst on
// following bytes with an incrementing address; without it those bytes are
// ignored and reads return 8'hFF.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_err
);

`ifdef SPI_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // A cs_n fall seen before the synchronizer has flushed its reset value
  // reflects a line that was already low during reset, not a new frame.
  localparam int             SETTLE     = SYNC_STAGES + 1;
  localparam int             SW         = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]  SETTLE_CNT = SW'(SETTLE);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_s;

  state_t              state_reg;
  logic [2:0]          bit_cnt_reg;
  logic [DATA_W-1:0]   rx_reg;
  logic [DATA_W-1:0]   tx_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                first_reg;
  logic                rd_wait_reg;
  logic [SW-1:0]       settle_cnt_reg;
  logic [DATA_W-1:0]   rx_byte;
  logic                burst_ok;
  logic                settled;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .din(sck), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi = gi + 1) begin : g_mosi
      if (gi == 0) begin : g_first
        // mosi only needs the level, delayed to stay aligned with sck
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) mosi_sync_reg[0] <= 1'b0;
          else        mosi_sync_reg[0] <= mosi;
        end
      end else begin : g_next
        // Remaining mosi synchronizer stages
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) mosi_sync_reg[gi] <= 1'b0;
          else        mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign rx_byte  = {rx_reg[DATA_W-2:0], mosi_s};
  assign burst_ok = first_reg | AUTOINC;
  assign settled  = (settle_cnt_reg == SETTLE_CNT);

  // Frame FSM: bit shifting, command decode, bus strobes and miso drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 3'd0;
      rx_reg         <= '0;
      tx_reg         <= '0;
      addr_reg       <= '0;
      first_reg      <= 1'b0;
      rd_wait_reg    <= 1'b0;
      settle_cnt_reg <= '0;
      miso           <= 1'b0;
      miso_oe        <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      rd_req         <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      rd_req      <= 1'b0;
      frame_err   <= 1'b0;
      rd_wait_reg <= rd_req;
      if (!settled) settle_cnt_reg <= settle_cnt_reg + SW'(1);

      if (cs_fall)      miso_oe <= 1'b1;
      else if (cs_rise) miso_oe <= 1'b0;

      if (state_reg == IDLE) begin
        bit_cnt_reg <= 3'd0;
        busy        <= 1'b0;
        miso        <= 1'b0;
        if (cs_fall && settled) begin
          state_reg <= CMD;
          busy      <= 1'b1;
        end
      end else if (cs_rise) begin
        // cs_n rise wins over any sck edge in the same cycle
        state_reg   <= IDLE;
        bit_cnt_reg <= 3'd0;
        busy        <= 1'b0;
        miso        <= 1'b0;
        rd_wait_reg <= 1'b0;
        frame_err   <= (bit_cnt_reg != 3'd0);
      end else begin
        if (sck_rise) begin
          rx_reg      <= rx_byte;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            case (state_reg)
              CMD: begin
                addr_reg  <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                first_reg <= 1'b1;
                if (rx_byte[CMD_RW_BIT]) begin
                  state_reg <= RDATA;
                  rd_req    <= 1'b1;
                  rd_addr   <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                end else begin
                  state_reg <= WDATA;
                end
              end
              WDATA: begin
                first_reg <= 1'b0;
                addr_reg  <= next_addr(addr_reg);
                if (burst_ok) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr_reg;
                  wr_data <= rx_byte;
                end
              end
              RDATA: begin
                first_reg <= 1'b0;
                addr_reg  <= next_addr(addr_reg);
                if (AUTOINC) begin
                  rd_req  <= 1'b1;
                  rd_addr <= next_addr(addr_reg);
                end else begin
                  tx_reg <= FILLER_BYTE;
                  miso   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        // Mid-byte falling edges shift out the next bit; the byte-boundary
        // fall is skipped because the next byte is loaded by the capture below
        if (sck_fall && state_reg == RDATA && bit_cnt_reg != 3'd0) begin
          miso   <= tx_reg[DATA_W-2];
          tx_reg <= {tx_reg[DATA_W-2:0], 1'b1};
        end

        // Register data arrives the cycle after the request is seen
        if (rd_wait_reg && state_reg == RDATA) begin
          tx_reg <= rd_data;
          miso   <= rd_data[DATA_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: write, read, abort, burst, reset and idle noise.
module tb_spi_target;

  localparam int H = 80;  // sck half period (16 clk periods per sck period)

`ifdef SPI_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wr_en, rd_req, busy, frame_err;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .frame_err(frame_err)
  );

  // Register file model: 0x05 holds 0x3C, other addresses hold addr ^ 0x96
  assign rd_data = (rd_addr == 7'h05) ? 8'h3C : ({1'b0, rd_addr} ^ 8'h96);

  // Bus activity monitor, sampled on the inactive clock edge
  int         wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, busy_cnt = 0, oe_cnt = 0, wr_long = 0;
  logic       wr_en_d = 1'b0;
  logic [6:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [6:0] rd_addr_log [64];

  always @(negedge clk) begin
    wr_en_d <= wr_en;
    if (wr_en && wr_en_d) wr_long <= wr_long + 1;
    if (wr_en) begin
      wr_addr_log[wr_cnt[5:0]] <= wr_addr;
      wr_data_log[wr_cnt[5:0]] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_req) begin
      rd_addr_log[rd_cnt[5:0]] <= rd_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
    if (miso_oe)   oe_cnt   <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full byte, MSB first; miso sampled just before each rising edge
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #(H);
      rx[i] = miso;
      sck = 1'b1;
      #(H);
      sck = 1'b0;
    end
  endtask

  // First n bits of a byte, MSB first (used to build aborted bytes)
  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #(H);
      sck = 1'b1;
      #(H);
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    #(H);
  endtask

  task automatic cs_end();
    #(H);
    cs_n = 1'b1;
    #(2 * H);
  endtask

  // Timeout guard: the stimulus is time-bounded, this only catches a stuck run
  initial begin
    #2ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w0, r0, f0, b0, o0;
    logic [7:0] rx, rx2;

    // Reset state
    #23;
    check("reset_outputs",
          {miso, miso_oe, wr_en, rd_req, busy, frame_err, wr_addr, wr_data, rd_addr}, 32'h0);
    #40;
    rst_n = 1'b1;
    #(2 * H);
    check("idle_busy", busy, 1'b0);

    // Single write 0x05 <- 0xA5
    w0 = wr_cnt; f0 = ferr_cnt;
    cs_start();
    spi_byte(8'h05, rx);
    check("wr_busy_mid", busy, 1'b1);
    check("wr_oe_mid", miso_oe, 1'b1);
    spi_byte(8'hA5, rx);
    cs_end();
    $display("write 05 A5: wr_en %0d addr %02h data %02h", wr_cnt - w0, wr_addr_log[w0[5:0]], wr_data_log[w0[5:0]]);
    check("wr_count", wr_cnt - w0, 1);
    check("wr_addr", wr_addr_log[w0[5:0]], 7'h05);
    check("wr_data", wr_data_log[w0[5:0]], 8'hA5);
    check("wr_ferr", ferr_cnt - f0, 0);
    check("wr_pulse_width", wr_long, 0);
    check("wr_busy_end", busy, 1'b0);

    // Single read 0x05 -> 0x3C
    r0 = rd_cnt;
    cs_start();
    spi_byte(8'h85, rx);
    check("rd_cmd_miso", rx, 8'h00);
    check("rd_req_count", rd_cnt - r0, 1);
    check("rd_addr", rd_addr_log[r0[5:0]], 7'h05);
    spi_byte(8'h00, rx);
    cs_end();
    $display("read 85: rd_req %0d addr %02h miso byte %02h", rd_cnt - r0, rd_addr_log[r0[5:0]], rx);
    check("rd_data_miso", rx, 8'h3C);
    check("rd_req_total", rd_cnt - r0, AUTOINC ? 2 : 1);
    check("rd_miso_idle", miso, 1'b0);
    check("rd_oe_idle", miso_oe, 1'b0);

    // Abort after 4 data bits of a write to 0x10, then a normal frame
    w0 = wr_cnt; f0 = ferr_cnt;
    cs_start();
    spi_byte(8'h10, rx);
    spi_bits(8'hF0, 4);
    cs_end();
    $display("abort 10 after 4 bits: wr_en %0d frame_err %0d busy %0b", wr_cnt - w0, ferr_cnt - f0, busy);
    check("abort_wr", wr_cnt - w0, 0);
    check("abort_ferr", ferr_cnt - f0, 1);
    check("abort_busy", busy, 1'b0);
    w0 = wr_cnt; f0 = ferr_cnt;
    cs_start();
    spi_byte(8'h12, rx);
    spi_byte(8'h99, rx);
    cs_end();
    $display("write 12 99: wr_en %0d addr %02h data %02h", wr_cnt - w0, wr_addr_log[w0[5:0]], wr_data_log[w0[5:0]]);
    check("after_abort_count", wr_cnt - w0, 1);
    check("after_abort_addr", wr_addr_log[w0[5:0]], 7'h12);
    check("after_abort_data", wr_data_log[w0[5:0]], 8'h99);
    check("after_abort_ferr", ferr_cnt - f0, 0);

    // Burst write at 0x7F: 0x11, 0x22
    w0 = wr_cnt;
    cs_start();
    spi_byte(8'h7F, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    cs_end();
    $display("burst write 7F 11 22: wr_en %0d", wr_cnt - w0);
    check("burst_count", wr_cnt - w0, AUTOINC ? 2 : 1);
    check("burst_addr0", wr_addr_log[w0[5:0]], 7'h7F);
    check("burst_data0", wr_data_log[w0[5:0]], 8'h11);
`ifdef SPI_TARGET_AUTOINC_EN
    check("burst_addr1", wr_addr_log[w0[5:0] + 6'd1], 7'h00);
    check("burst_data1", wr_data_log[w0[5:0] + 6'd1], 8'h22);
`endif

    // Burst read at 0x05: second data byte is 0x90 (addr 0x06) or filler 0xFF
    cs_start();
    spi_byte(8'h85, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx2);
    cs_end();
    $display("burst read 85: bytes %02h %02h", rx, rx2);
    check("burst_rd0", rx, 8'h3C);
    check("burst_rd1", rx2, AUTOINC ? 8'h90 : 8'hFF);

    // Reset during the data byte of a write to 0x01
    w0 = wr_cnt; f0 = ferr_cnt;
    cs_start();
    spi_byte(8'h01, rx);
    spi_bits(8'h55, 4);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          {miso, miso_oe, wr_en, rd_req, busy, frame_err, wr_addr, wr_data, rd_addr}, 32'h0);
    #(H);
    rst_n = 1'b1;
    spi_bits(8'h50, 4);
    cs_end();
    $display("reset mid write 01: wr_en %0d frame_err %0d", wr_cnt - w0, ferr_cnt - f0);
    check("reset_no_wr", wr_cnt - w0, 0);
    check("reset_no_ferr", ferr_cnt - f0, 0);
    w0 = wr_cnt;
    cs_start();
    spi_byte(8'h01, rx);
    spi_byte(8'h55, rx);
    cs_end();
    $display("write 01 55: wr_en %0d addr %02h data %02h", wr_cnt - w0, wr_addr_log[w0[5:0]], wr_data_log[w0[5:0]]);
    check("post_reset_count", wr_cnt - w0, 1);
    check("post_reset_addr", wr_addr_log[w0[5:0]], 7'h01);
    check("post_reset_data", wr_data_log[w0[5:0]], 8'h55);

    // Idle noise: 16 sck toggles with cs_n high
    w0 = wr_cnt; r0 = rd_cnt; f0 = ferr_cnt; b0 = busy_cnt; o0 = oe_cnt;
    for (int i = 0; i < 16; i++) begin
      sck  = ~sck;
      mosi = 1'($urandom_range(0, 1));
      #(H / 2);
    end
    #(2 * H);
    $display("idle noise: wr %0d rd %0d ferr %0d busy %0d oe %0d",
             wr_cnt - w0, rd_cnt - r0, ferr_cnt - f0, busy_cnt - b0, oe_cnt - o0);
    check("noise_wr", wr_cnt - w0, 0);
    check("noise_rd", rd_cnt - r0, 0);
    check("noise_ferr", ferr_cnt - f0, 0);
    check("noise_busy", busy_cnt - b0, 0);
    check("noise_oe", oe_cnt - o0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
